// File: rtl/pause_sprite_packer.sv
// Scans the pause-sprite bounding box through a 1-cycle LUT and packs the returned bits into frame-buffer words.
// Latency: first address one cycle after start; each bit is captured the cycle after it is issued; a word is offered the cycle after its last bit.
// Backpressure: an address is issued only if its bit can be absorbed next cycle; the address holds while stalled.
module pause_sprite_packer #(
    parameter logic [11:0] X_START   = 12'h005,
    parameter logic [11:0] X_END     = 12'h057,
    parameter logic [11:0] Y_START   = 12'h029,
    parameter logic [11:0] Y_END     = 12'h039,
    parameter int          WORD_W    = 16,
    parameter int          ADDR_W    = 16,
    parameter int          BASE_ADDR = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    output logic [23:0]       lut_addr,
    input  logic              lut_bit,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);
    localparam int POS_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [11:0]       x_cnt, y_cnt;
    logic [POS_W-1:0]  bit_pos;
    logic [ADDR_W-1:0] word_addr;

    logic              inflt_vld, inflt_last;
    logic [POS_W-1:0]  inflt_pos;
    logic [ADDR_W-1:0] inflt_addr;
    logic [WORD_W-1:0] shreg, cap_word;

    logic row_end, last_addr, word_end, cap_last, accept, hold_free_next, issue;

    assign lut_addr  = {x_cnt, y_cnt};
    assign busy      = (state != IDLE);
    assign row_end   = (x_cnt == X_END);
    assign last_addr = row_end && (y_cnt == Y_END);
    assign word_end  = row_end || (bit_pos == POS_W'(WORD_W - 1));
    assign cap_last  = inflt_vld && inflt_last;
    assign accept    = wr_valid && wr_ready;

    // The holding reg is only guaranteed free next cycle if it drains now and nothing lands in it now.
    assign hold_free_next = (!wr_valid || wr_ready) && !cap_last;
    assign issue          = (state == SCAN) && (!word_end || hold_free_next);

    always_comb begin
        cap_word            = (inflt_pos == '0) ? '0 : shreg;
        cap_word[inflt_pos] = cap_word[inflt_pos] | lut_bit;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (issue && last_addr) state_nxt = DRAIN;
            DRAIN: begin
                if (!inflt_vld && accept) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            bit_pos    <= '0;
            word_addr  <= '0;
            inflt_vld  <= 1'b0;
            inflt_last <= 1'b0;
            inflt_pos  <= '0;
            inflt_addr <= '0;
            shreg      <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            if (state == IDLE && start) begin
                x_cnt     <= X_START;
                y_cnt     <= Y_START;
                bit_pos   <= '0;
                word_addr <= ADDR_W'(BASE_ADDR);
            end else if (issue) begin
                if (row_end) begin
                    bit_pos <= '0;
                    if (last_addr) begin
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end else begin
                        x_cnt <= X_START;
                        y_cnt <= y_cnt + 12'd1;
                    end
                end else begin
                    x_cnt   <= x_cnt + 12'd1;
                    bit_pos <= word_end ? '0 : bit_pos + POS_W'(1);
                end
                if (word_end) word_addr <= word_addr + ADDR_W'(1);
            end

            inflt_vld  <= issue;
            inflt_last <= word_end;
            inflt_pos  <= bit_pos;
            inflt_addr <= word_addr;

            if (inflt_vld) shreg <= cap_word;

            if (cap_last) begin
                wr_valid <= 1'b1;
                wr_addr  <= inflt_addr;
                wr_data  <= cap_word;
            end else if (accept) begin
                wr_valid <= 1'b0;
            end
        end
    end
endmodule
